cam_param: RTL
==============

Name: cam_param

Overview:
- Parametrised successor to the 32x32 CAM. Configurable depth and data width.
- Adds per-entry invalidate, a single-cycle flush, a masked (ternary) search key, registered one-cycle search and read pipelines, multi-hit detection, and free-entry tracking.
- Sits in the same lookup datapath as the fixed CAM and is driven by the same control logic. The extra outputs feed allocation logic.

Parameters:
- DEPTH, 32, number of entries; any integer ≥ 2, need not be a power of two.
- DATA_WIDTH, 32, bits per entry and per search key.
- INDEX_WIDTH, $clog2(DEPTH), width of all index ports; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- write_enable_i  input  1  write write_data_i into entry write_index_i and set its valid bit.
- write_index_i  input  INDEX_WIDTH  target entry for write.
- write_data_i  input  DATA_WIDTH  data to store.
- invalidate_i  input  1  clear valid bit of entry write_index_i.
- flush_i  input  1  clear all valid bits.
- read_enable_i  input  1  request read of entry read_index_i.
- read_index_i  input  INDEX_WIDTH  entry to read.
- read_value_o  output  DATA_WIDTH  registered read data.
- read_valid_o  output  1  registered valid bit of the read entry.
- read_ack_o  output  1  pulses one cycle after an accepted read.
- search_enable_i  input  1  start a search this cycle.
- search_data_i  input  DATA_WIDTH  search key.
- search_mask_i  input  DATA_WIDTH  1 = compare bit, 0 = don't care.
- search_valid_o  output  1  registered: at least one valid entry matched.
- search_index_o  output  INDEX_WIDTH  lowest matching index.
- search_multi_o  output  1  two or more valid entries matched.
- search_ack_o  output  1  pulses one cycle after an accepted search.
- full_o  output  1  all entries valid.
- free_index_o  output  INDEX_WIDTH  lowest invalid index; 0 when full.

Behaviour:
- Reset (rst_i=1 at edge):
  - All valid bits go to 0. Storage contents are not cleared.
  - Every output is 0, except free_index_o, which is 0 because entry 0 is free.
  - Reset overrides all other requests in the same cycle.
- Write: entry data ← write_data_i and valid ← 1 at the edge. Both are visible to searches and reads issued in the following cycle.
- Out-of-range write_index_i (≥ DEPTH): the write and any invalidate are ignored with no side effects.
- Invalidate: valid ← 0 for the indexed entry. Stored data is unchanged.
- Priority on the same edge for the same entry: flush_i > invalidate_i > write_enable_i. If flush and write coincide, every valid bit ends 0, including the written entry. If invalidate and write coincide, valid ends 0 and the data is still written.
- Match rule: an entry matches iff valid and ((entry ^ search_data_i) & search_mask_i) == 0. An all-zero mask matches every valid entry.
- Search pipeline:
  - Combinational compare on the pre-edge state; results are registered.
  - Latency 1: outputs are valid in the cycle after search_enable_i, with search_ack_o=1.
  - A search and a write/invalidate/flush in the same cycle compare against the old contents.
  - Back-to-back searches are accepted every cycle.
  - With no hit: search_valid_o=0, search_index_o=0, search_multi_o=0.
  - When no search is issued: search_ack_o=0. The other search outputs hold their last values.
- Priority encoder: lowest index wins. search_multi_o is set iff popcount(matches) ≥ 2.
- Read pipeline:
  - Latency 1: read_value_o ← entry data and read_valid_o ← valid bit (pre-edge state). read_ack_o=1 in the next cycle.
  - Out-of-range index: read_value_o=0, read_valid_o=0, and read_ack_o still pulses.
  - Outputs hold their last values when idle.
- Allocation status:
  - full_o and free_index_o are combinational from the valid bits.
  - They reflect a write at the edge starting the next cycle.
- Reset mid-operation: a search or read in flight when rst_i is asserted is dropped. Its ack and results are forced to 0.

Test Plan:
- Reset, then write 0xDEADBEEF to idx 5 and search key 0xDEADBEEF with mask all-ones → one cycle later: search_valid_o=1, search_index_o=5, search_multi_o=0, search_ack_o=1.
- Write 0x12340000 to idx 3 and 0x1234FFFF to idx 9, then search key 0x12340000 with mask 0xFFFF0000 → search_index_o=3, search_multi_o=1. Repeat with mask 0xFFFFFFFF → index 3, multi=0.
- Write idx 7 and search the same data in the same cycle → search_valid_o=0. Repeat the search the next cycle → valid=1, index 7.
- Fill all DEPTH entries → full_o=1, free_index_o=0. Invalidate idx 4 → next cycle full_o=0, free_index_o=4. A search for idx 4's data → search_valid_o=0.
- Write and flush together on idx 2 → next cycle a search misses and full_o=0. Read idx 2 → read_valid_o=0 while read_value_o shows the written data.
- Issue a search, assert rst_i in the next cycle → search_ack_o=0 and all search outputs are 0. Read out-of-range index DEPTH → read_ack_o=1, read_valid_o=0, read_value_o=0.

Source files
------------

// File: rtl/cam_param_if.sv
// cam_param_if: bundles the request/response signals of cam_param.
//   master modport: drives write/invalidate/flush, read and search requests
//                   and observes the read, search and allocation results.
//   slave modport:  the CAM side; takes the requests and drives the results.
// Signal names keep their _i/_o suffixes as seen from the CAM.
interface cam_param_if #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int INDEX_WIDTH = $clog2(DEPTH);

    logic                   write_enable_i;
    logic [INDEX_WIDTH-1:0] write_index_i;
    logic [DATA_WIDTH-1:0]  write_data_i;
    logic                   invalidate_i;
    logic                   flush_i;
    logic                   read_enable_i;
    logic [INDEX_WIDTH-1:0] read_index_i;
    logic [DATA_WIDTH-1:0]  read_value_o;
    logic                   read_valid_o;
    logic                   read_ack_o;
    logic                   search_enable_i;
    logic [DATA_WIDTH-1:0]  search_data_i;
    logic [DATA_WIDTH-1:0]  search_mask_i;
    logic                   search_valid_o;
    logic [INDEX_WIDTH-1:0] search_index_o;
    logic                   search_multi_o;
    logic                   search_ack_o;
    logic                   full_o;
    logic [INDEX_WIDTH-1:0] free_index_o;

    modport master (
        output write_enable_i, write_index_i, write_data_i, invalidate_i, flush_i,
        output read_enable_i, read_index_i,
        output search_enable_i, search_data_i, search_mask_i,
        input  read_value_o, read_valid_o, read_ack_o,
        input  search_valid_o, search_index_o, search_multi_o, search_ack_o,
        input  full_o, free_index_o
    );

    modport slave (
        input  write_enable_i, write_index_i, write_data_i, invalidate_i, flush_i,
        input  read_enable_i, read_index_i,
        input  search_enable_i, search_data_i, search_mask_i,
        output read_value_o, read_valid_o, read_ack_o,
        output search_valid_o, search_index_o, search_multi_o, search_ack_o,
        output full_o, free_index_o
    );
endinterface

// File: rtl/cam_param.sv
// cam_param: parametrised content-addressable memory.
//   DEPTH entries of DATA_WIDTH bits, each with a valid bit. Supports write,
//   per-entry invalidate, single-cycle flush, a masked search with one-cycle
//   registered results (lowest hit index + multi-hit flag), a one-cycle
//   registered read, and combinational free-entry tracking.
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset (clears valid bits and outputs)
//   bus    - cam_param_if.slave carrying requests and results
module cam_param #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    cam_param_if.slave  bus
);
    localparam int INDEX_WIDTH = $clog2(DEPTH);
    // DEPTH widened by one bit so any index value can be range-checked.
    localparam logic [INDEX_WIDTH:0] DEPTH_W = (INDEX_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]       r_valid;

    logic [DATA_WIDTH-1:0]  r_read_value;
    logic                   r_read_valid;
    logic                   r_read_ack;
    logic                   r_search_valid;
    logic [INDEX_WIDTH-1:0] r_search_index;
    logic                   r_search_multi;
    logic                   r_search_ack;

    logic                   w_wr_in_range;
    logic                   w_rd_in_range;
    logic [DEPTH-1:0]       w_match;
    logic                   w_hit_any;
    logic                   w_hit_multi;
    logic [INDEX_WIDTH-1:0] w_hit_index;
    logic                   w_free_found;
    logic [INDEX_WIDTH-1:0] w_free_index;

    assign w_wr_in_range = ({1'b0, bus.write_index_i} < DEPTH_W);
    assign w_rd_in_range = ({1'b0, bus.read_index_i} < DEPTH_W);

    // Data is written whenever the write is in range, even if a coincident
    // flush or invalidate leaves the entry invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.write_enable_i && w_wr_in_range) begin
            r_mem[bus.write_index_i] <= bus.write_data_i;
        end
    end

    // Valid bits: flush beats invalidate beats write.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_valid <= '0;
        end else if (w_wr_in_range) begin
            if (bus.invalidate_i) begin
                r_valid[bus.write_index_i] <= 1'b0;
            end else if (bus.write_enable_i) begin
                r_valid[bus.write_index_i] <= 1'b1;
            end
        end
    end

    // Per-entry ternary compare against the pre-edge contents.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] &&
                (((r_mem[gi] ^ bus.search_data_i) & bus.search_mask_i) == '0);
        end
    endgenerate

    // Lowest-index priority encoder; any later hit marks a multi-hit.
    always_comb begin
        w_hit_any   = 1'b0;
        w_hit_multi = 1'b0;
        w_hit_index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                if (w_hit_any) begin
                    w_hit_multi = 1'b1;
                end else begin
                    w_hit_any   = 1'b1;
                    w_hit_index = INDEX_WIDTH'(i);
                end
            end
        end
    end

    // Lowest free entry; stays 0 when every entry is valid.
    always_comb begin
        w_free_found = 1'b0;
        w_free_index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_index = INDEX_WIDTH'(i);
            end
        end
    end

    // Search results hold their value between searches; only the ack is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_search_ack   <= 1'b0;
            r_search_valid <= 1'b0;
            r_search_index <= '0;
            r_search_multi <= 1'b0;
        end else begin
            r_search_ack <= bus.search_enable_i;
            if (bus.search_enable_i) begin
                r_search_valid <= w_hit_any;
                r_search_index <= w_hit_index;
                r_search_multi <= w_hit_multi;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_read_ack   <= 1'b0;
            r_read_value <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_ack <= bus.read_enable_i;
            if (bus.read_enable_i) begin
                if (w_rd_in_range) begin
                    r_read_value <= r_mem[bus.read_index_i];
                    r_read_valid <= r_valid[bus.read_index_i];
                end else begin
                    r_read_value <= '0;
                    r_read_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.read_value_o   = r_read_value;
    assign bus.read_valid_o   = r_read_valid;
    assign bus.read_ack_o     = r_read_ack;
    assign bus.search_valid_o = r_search_valid;
    assign bus.search_index_o = r_search_index;
    assign bus.search_multi_o = r_search_multi;
    assign bus.search_ack_o   = r_search_ack;
    assign bus.full_o         = &r_valid;
    assign bus.free_index_o   = w_free_index;
endmodule
